// File: rtl/ec_pkg.sv
// Shared definitions for the erasure-code engine scheduler: default sizing
// and the scheduler state type.
package ec_pkg;

  localparam int M_MAX_DEF   = 8;
  localparam int LINES_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    CALC,
    DONE
  } sched_state_e;

endpackage

// File: rtl/ec_eng_sched_if.sv
// FIFO and engine handshake bundle between the scheduler (master) and the
// input buffer, parity engine and output buffer (slave).
interface ec_eng_sched_if import ec_pkg::*; #(
  parameter int M_W = $clog2(M_MAX_DEF + 1)
);

  logic           inbuf_fifo_empty;
  logic           inbuf_rd_data_val;
  logic           outbuf_fifo_full;
  logic           inbuf_fifo_rd_rq;
  logic           eng_calc_en;
  logic [M_W-1:0] eng_row_idx;
  logic           eng_last_row;
  logic           outbuf_fifo_wr_rq;

  modport master (
    input  inbuf_fifo_empty, inbuf_rd_data_val, outbuf_fifo_full,
    output inbuf_fifo_rd_rq, eng_calc_en, eng_row_idx, eng_last_row,
           outbuf_fifo_wr_rq
  );

  modport slave (
    output inbuf_fifo_empty, inbuf_rd_data_val, outbuf_fifo_full,
    input  inbuf_fifo_rd_rq, eng_calc_en, eng_row_idx, eng_last_row,
           outbuf_fifo_wr_rq
  );

endinterface

// File: rtl/ec_mod_counter.sv
// Modulo counter: counts enabled cycles from 0 to modulus-1 and flags the
// enabled cycle on which it wraps back to 0. Clear beats enable.
module ec_mod_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == modulus - W'(1));

  // Count register: clear first, then wrap to zero on the last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (clr)  count <= '0;
    else if (wrap) count <= '0;
    else if (en)   count <= count + W'(1);
  end

endmodule

// File: rtl/ec_eng_sched.sv
// Parity engine scheduler: for each data line of a job it pops the line from
// the input FIFO, waits for the read data, then steps the engine through M
// parity rows, pushing one row per cycle into the output FIFO.
module ec_eng_sched import ec_pkg::*; #(
  parameter int M_MAX   = M_MAX_DEF,
  parameter int M_W     = $clog2(M_MAX + 1),
  parameter int LINES_W = LINES_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               soft_clr,
  input  logic               start,
  input  logic [M_W-1:0]     m_cfg,
  input  logic [LINES_W-1:0] lines_cfg,
  ec_eng_sched_if.master     bus,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  sched_state_e       state, state_nxt;
  logic [M_W-1:0]     m_lat;
  logic [LINES_W-1:0] lines_lat;
  logic [LINES_W-1:0] line_cnt;
  logic [M_W-1:0]     row;
  logic               cfg_ok;
  logic               start_ok;
  logic               start_bad;
  logic               row_en;
  logic               row_clr;
  logic               row_wrap;
  logic               last_line;
  logic               rd_rq;

  assign cfg_ok    = (m_cfg != '0) && (m_cfg <= M_W'(M_MAX)) && (lines_cfg != '0);
  assign start_ok  = (state == IDLE) && start && !soft_clr && cfg_ok;
  assign start_bad = (state == IDLE) && start && !soft_clr && !cfg_ok;
  assign row_en    = (state == CALC) && !bus.outbuf_fifo_full && !soft_clr;
  assign row_clr   = soft_clr || (state == IDLE);
  assign last_line = (line_cnt == lines_lat - LINES_W'(1));

  ec_mod_counter #(.W(M_W)) u_row_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (row_en),
    .clr     (row_clr),
    .modulus (m_lat),
    .count   (row),
    .wrap    (row_wrap)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and FIFO read request; soft_clr overrides everything.
  always_comb begin
    state_nxt = state;
    rd_rq     = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = FETCH;
      FETCH: begin
        rd_rq = !bus.inbuf_fifo_empty;
        if (rd_rq) state_nxt = WAIT;
      end
      WAIT:  if (bus.inbuf_rd_data_val) state_nxt = CALC;
      CALC:  if (row_wrap) state_nxt = last_line ? DONE : FETCH;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (soft_clr) begin
      state_nxt = IDLE;
      rd_rq     = 1'b0;
    end
  end

  // Job configuration is captured only on an accepted start so later input
  // changes cannot disturb a running job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lat     <= '0;
      lines_lat <= '0;
    end else if (start_ok) begin
      m_lat     <= m_cfg;
      lines_lat <= lines_cfg;
    end
  end

  // Line counter advances each time the last parity row of a line is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       line_cnt <= '0;
    else if (soft_clr || start_ok) line_cnt <= '0;
    else if (row_wrap)             line_cnt <= line_cnt + LINES_W'(1);
  end

  // Illegal start is reported as a single-cycle pulse one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= start_bad;
  end

  assign bus.inbuf_fifo_rd_rq  = rd_rq;
  assign bus.eng_calc_en       = row_en;
  assign bus.outbuf_fifo_wr_rq = row_en;
  assign bus.eng_row_idx       = row;
  assign bus.eng_last_row      = (state == CALC) && (row == m_lat - M_W'(1));
  assign busy                  = (state != IDLE);
  assign done                  = (state == DONE);

endmodule

// File: doc/ec_eng_sched.md
EC_ENG_SCHED -- requirements
Module: ec_eng_sched

Interface
REQ-001 The block SHALL use parameter M_MAX, default 8, as the maximum number of parity rows (M) per data line.
REQ-002 The block SHALL use parameter M_W, default $clog2(M_MAX+1), as the width of the M configuration and row index.
REQ-003 The block SHALL use parameter LINES_W, default 16, as the width of the data-line count.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port soft_clr, input, 1 bit: synchronous engine clear.
REQ-007 The block SHALL have port start, input, 1 bit: job start pulse.
REQ-008 The block SHALL have port m_cfg, input, M_W bits: M, the parity rows per line.
REQ-009 The block SHALL have port lines_cfg, input, LINES_W bits: the data lines per job.
REQ-010 The block SHALL have port inbuf_fifo_empty, input, 1 bit: input FIFO empty.
REQ-011 The block SHALL have port inbuf_rd_data_val, input, 1 bit: FIFO read data valid, one cycle after a read request.
REQ-012 The block SHALL have port outbuf_fifo_full, input, 1 bit: output FIFO full.
REQ-013 The block SHALL have port inbuf_fifo_rd_rq, output, 1 bit: pop one data line.
REQ-014 The block SHALL have port eng_calc_en, output, 1 bit: engine computes one parity row this cycle.
REQ-015 The block SHALL have port eng_row_idx, output, M_W bits: the current parity row, 0..M-1.
REQ-016 The block SHALL have port eng_last_row, output, 1 bit: the current row is M-1.
REQ-017 The block SHALL have port outbuf_fifo_wr_rq, output, 1 bit: push one parity row.
REQ-018 The block SHALL have port busy, output, 1 bit: a job is active.
REQ-019 The block SHALL have port done, output, 1 bit: one-cycle job-complete pulse.
REQ-020 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse on an illegal start.

Function
REQ-021 The FSM SHALL have states IDLE, FETCH, WAIT, CALC and DONE.
REQ-022 In IDLE, a start with m_cfg!=0, m_cfg<=M_MAX and lines_cfg!=0 SHALL latch the configuration, clear the counters and go to FETCH; any other start SHALL pulse cfg_err the next cycle and keep the FSM in IDLE.
REQ-023 A start outside IDLE SHALL be ignored, and a configuration change mid-job SHALL NOT affect the latched values.
REQ-024 In FETCH, inbuf_fifo_rd_rq SHALL equal ~inbuf_fifo_empty (combinational); when it is 1 the FSM SHALL go to WAIT, otherwise it SHALL stay in FETCH.
REQ-025 In WAIT, inbuf_rd_data_val SHALL move the FSM to CALC with the row counter at 0; without it the FSM SHALL stay in WAIT with no timeout.
REQ-026 In CALC, eng_calc_en and outbuf_fifo_wr_rq SHALL both equal ~outbuf_fifo_full; a full cycle SHALL stall with the row counter held.
REQ-027 eng_row_idx SHALL equal the row counter, and eng_last_row SHALL equal (row==M-1) while in CALC and 0 elsewhere.
REQ-028 On an enabled cycle with row==M-1, the row counter SHALL wrap to 0 and the line counter SHALL increment; the FSM SHALL go to DONE if the line counter equals lines_cfg-1, otherwise to FETCH.
REQ-029 M=1 SHALL give a single CALC cycle per line, with eng_last_row=1.
REQ-030 DONE SHALL last one cycle with done=1 and then go to IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 soft_clr SHALL take priority over all transitions: the next state is IDLE, the counters clear, and no done is issued.
REQ-033 inbuf_fifo_rd_rq, eng_calc_en and outbuf_fifo_wr_rq SHALL be 0 when soft_clr=1.
REQ-034 With no stalls and read latency 1, a job SHALL take 1 + lines*(2+M) cycles from start to done.

Reset
REQ-035 While rst=1, the FSM SHALL be in IDLE, the counters and latched configuration SHALL be 0, and every output SHALL be 0.
REQ-036 rst SHALL act asynchronously; the first active edge after its release SHALL be evaluated from IDLE.

Structure
REQ-037 The state enum and the M_MAX and LINES_W defaults SHALL live in the shared package ec_pkg.
REQ-038 The row counter SHALL be the sub-module ec_mod_counter (enable, clear, modulus, wrap flag).
REQ-039 The FSM and the line counter SHALL stay inside ec_eng_sched.

Verification
REQ-040 The bench SHALL cover: M=3, lines=2, no stalls, start at cycle 0 -> rd_rq at cycles 1 and 6, calc_en at cycles 3-5 and 8-10 with row_idx 0,1,2, done at cycle 11.
REQ-041 The bench SHALL cover: M=4, lines=1, outbuf_fifo_full held for the 2 cycles at row 1 -> row_idx holds 1 with calc_en=0, and done arrives 2 cycles later than with no stall.
REQ-042 The bench SHALL cover: start with m_cfg=0, and start with lines_cfg=0 -> cfg_err pulse, busy stays 0, and no rd_rq is issued.
REQ-043 The bench SHALL cover: inbuf_fifo_empty=1 for 5 cycles in FETCH -> rd_rq stays 0 and the FSM holds, with a read issued on the first non-empty cycle.
REQ-044 The bench SHALL cover: soft_clr asserted at row 2 of line 1 -> IDLE next cycle, busy=0, no done, and a new start then runs a full job.
REQ-045 The bench SHALL cover: rst asserted asynchronously mid-CALC -> all outputs go to 0 immediately.
